// File: rtl/rv32i_mem_stage.sv
// ---------------------------------------------------------------------------
// rv32i_mem_stage
//   Memory stage of a simple in-order RV32I pipeline. Non-memory instructions
//   pass straight through to the writeback registers with one cycle of
//   latency. Loads and stores park the stage in WAIT, hold a single request
//   on the data-memory port until dmem_ack arrives or WAIT_MAX cycles pass,
//   and then emit the instruction to writeback (extended load data for loads,
//   the original address for stores).
//
//   Handshake: an instruction is transferred on a rising clk edge where
//   ex_valid=1 and ex_ready=1. ex_ready is high exactly while the stage is
//   IDLE. The memory side keeps dmem_req high with stable we/addr/be/wdata
//   until the edge on which dmem_ack=1 is seen or the access times out.
//
//   Optional feature (macro MISALIGN_TRAP_EN):
//     defined   - adds misalign_out; misaligned halfword/word accesses make
//                 no memory access and complete in one cycle with
//                 wb_en_out=0 and misalign_out=1.
//     undefined - halfword accesses ignore addr[0], word accesses ignore
//                 addr[1:0].
//
//   Ports
//     clk, reset          clock, asynchronous active-low reset
//     ex_valid/ex_ready   execute-stage handshake
//     ex_pc, ex_iw        instruction address / instruction word
//     ex_alu              ALU result (effective address for loads/stores)
//     ex_rs2              store data
//     ex_wb_en, ex_wb_reg writeback control
//     dmem_*              word-aligned data memory request/response
//     pc_out .. bus_err   registered writeback-stage feed
//     misalign_out        misalignment trap pulse (MISALIGN_TRAP_EN only)
//     state_dbg           1 while the stage is in WAIT
// ---------------------------------------------------------------------------
module rv32i_mem_stage #(
    parameter int WAIT_MAX = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ex_valid,
    output logic        ex_ready,
    input  logic [31:0] ex_pc,
    input  logic [31:0] ex_iw,
    input  logic [31:0] ex_alu,
    input  logic [31:0] ex_rs2,
    input  logic        ex_wb_en,
    input  logic [4:0]  ex_wb_reg,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic [31:0] pc_out,
    output logic [31:0] iw_out,
    output logic [31:0] alu_out,
    output logic        wb_en_out,
    output logic [4:0]  wb_reg_out,
    output logic        bus_err,
`ifdef MISALIGN_TRAP_EN
    output logic        misalign_out,
`endif
    output logic        state_dbg
);

    typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    // Value of wait_cnt during the last allowed WAIT cycle.
    localparam logic [7:0] CNT_LAST = 8'(WAIT_MAX - 1);

    state_t      state, state_next;
    logic [7:0]  wait_cnt;

    // Instruction captured while the access is outstanding.
    logic [31:0] cap_pc, cap_iw, cap_alu;
    logic        cap_wb_en;
    logic [4:0]  cap_wb_reg;

    // Execute-side decode.
    logic [2:0]  funct3;
    logic        is_load, is_store, load_ok, store_ok, mem_ok, misaligned, mem_go;
    logic [1:0]  off;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        accept, wait_hit;

    // Response-side decode.
    logic [2:0]  cap_funct3;
    logic [1:0]  cap_off;
    logic        cap_load;
    logic [31:0] lane;
    logic [31:0] load_data;

    // Byte offset of the accessed lane. Halfwords are forced onto an even
    // lane and words onto lane 0, which is how unaligned addresses are
    // folded when no trap is taken.
    function automatic logic [1:0] lane_off(input logic [1:0] size, input logic [1:0] a);
        case (size)
            2'b00:   return a;
            2'b01:   return {a[1], 1'b0};
            default: return 2'b00;
        endcase
    endfunction

    assign ex_ready  = (state == IDLE);
    assign state_dbg = (state == WAIT);
    assign accept    = ex_valid && (state == IDLE);
    assign wait_hit  = (wait_cnt == CNT_LAST);

    always_comb begin
        funct3   = ex_iw[14:12];
        is_load  = (ex_iw[6:0] == OP_LOAD);
        is_store = (ex_iw[6:0] == OP_STORE);
        // Loads: LB LH LW LBU LHU. Stores: SB SH SW.
        load_ok  = is_load && (funct3 != 3'b011) && (funct3 != 3'b110) && (funct3 != 3'b111);
        store_ok = is_store && (funct3 <= 3'b010);
        mem_ok   = load_ok || store_ok;
`ifdef MISALIGN_TRAP_EN
        misaligned = mem_ok &&
                     (((funct3[1:0] == 2'b01) && ex_alu[0]) ||
                      ((funct3[1:0] == 2'b10) && (ex_alu[1:0] != 2'b00)));
`else
        misaligned = 1'b0;
`endif
        mem_go = mem_ok && !misaligned;
        off    = lane_off(funct3[1:0], ex_alu[1:0]);
        case (funct3[1:0])
            2'b00: begin
                be    = 4'b0001 << off;
                wdata = {4{ex_rs2[7:0]}};
            end
            2'b01: begin
                be    = 4'b0011 << off;
                wdata = {2{ex_rs2[15:0]}};
            end
            default: begin
                be    = 4'b1111;
                wdata = ex_rs2;
            end
        endcase
    end

    always_comb begin
        cap_funct3 = cap_iw[14:12];
        cap_load   = (cap_iw[6:0] == OP_LOAD);
        cap_off    = lane_off(cap_funct3[1:0], cap_alu[1:0]);
        // Move the addressed lane down to bit 0 before extension.
        lane       = dmem_rdata >> {cap_off, 3'b000};
        case (cap_funct3)
            3'b000:  load_data = {{24{lane[7]}}, lane[7:0]};
            3'b001:  load_data = {{16{lane[15]}}, lane[15:0]};
            3'b100:  load_data = {24'h000000, lane[7:0]};
            3'b101:  load_data = {16'h0000, lane[15:0]};
            default: load_data = dmem_rdata;
        endcase
    end

    // FSM: state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM: next state
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept && mem_go) state_next = WAIT;
            WAIT:    if (dmem_ack || wait_hit) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath, memory port and writeback registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_cnt   <= 8'd0;
            cap_pc     <= 32'd0;
            cap_iw     <= 32'd0;
            cap_alu    <= 32'd0;
            cap_wb_en  <= 1'b0;
            cap_wb_reg <= 5'd0;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= 32'd0;
            dmem_be    <= 4'd0;
            dmem_wdata <= 32'd0;
            pc_out     <= 32'd0;
            iw_out     <= 32'd0;
            alu_out    <= 32'd0;
            wb_en_out  <= 1'b0;
            wb_reg_out <= 5'd0;
            bus_err    <= 1'b0;
`ifdef MISALIGN_TRAP_EN
            misalign_out <= 1'b0;
`endif
        end else begin
            // Bubble unless a result is produced this cycle.
            wb_en_out <= 1'b0;
            bus_err   <= 1'b0;
`ifdef MISALIGN_TRAP_EN
            misalign_out <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (mem_go) begin
                            cap_pc     <= ex_pc;
                            cap_iw     <= ex_iw;
                            cap_alu    <= ex_alu;
                            cap_wb_en  <= ex_wb_en;
                            cap_wb_reg <= ex_wb_reg;
                            wait_cnt   <= 8'd0;
                            dmem_req   <= 1'b1;
                            dmem_we    <= store_ok;
                            dmem_addr  <= {ex_alu[31:2], 2'b00};
                            dmem_be    <= be;
                            dmem_wdata <= wdata;
                        end else begin
                            // Pass-through; memory opcodes that make no
                            // access (bad funct3, misaligned) never write back.
                            pc_out     <= ex_pc;
                            iw_out     <= ex_iw;
                            alu_out    <= ex_alu;
                            wb_reg_out <= ex_wb_reg;
                            wb_en_out  <= ex_wb_en && !is_load && !is_store;
`ifdef MISALIGN_TRAP_EN
                            misalign_out <= misaligned;
`endif
                        end
                    end
                end
                WAIT: begin
                    // Ack wins over the timeout when both land together.
                    if (dmem_ack || wait_hit) begin
                        dmem_req   <= 1'b0;
                        dmem_we    <= 1'b0;
                        dmem_addr  <= 32'd0;
                        dmem_be    <= 4'd0;
                        dmem_wdata <= 32'd0;
                        wait_cnt   <= 8'd0;
                        pc_out     <= cap_pc;
                        iw_out     <= cap_iw;
                        wb_reg_out <= cap_wb_reg;
                        if (dmem_ack) begin
                            alu_out   <= cap_load ? load_data : cap_alu;
                            wb_en_out <= cap_load && cap_wb_en;
                        end else begin
                            alu_out   <= cap_alu;
                            bus_err   <= 1'b1;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_rv32i_mem_stage.sv
// ---------------------------------------------------------------------------
// tb_rv32i_mem_stage
//   Self-checking bench for rv32i_mem_stage. Each scenario task drives an
//   instruction, pushes the expected writeback result onto exp_q and pops it
//   when the stage delivers. Expected load data, byte enables and store data
//   come from small reference functions written from the ISA behaviour.
//   Define MISALIGN_TRAP_EN to exercise the trap variant.
// ---------------------------------------------------------------------------
module tb_rv32i_mem_stage;

    localparam int WMAX = 4;
    localparam int EW   = 103;   // {pc, iw, alu, wb_en, wb_reg, bus_err}

    logic        clk;
    logic        reset;
    logic        ex_valid;
    logic        ex_ready;
    logic [31:0] ex_pc, ex_iw, ex_alu, ex_rs2;
    logic        ex_wb_en;
    logic [4:0]  ex_wb_reg;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic [31:0] pc_out, iw_out, alu_out;
    logic        wb_en_out;
    logic [4:0]  wb_reg_out;
    logic        bus_err;
`ifdef MISALIGN_TRAP_EN
    logic        misalign_out;
`endif
    logic        state_dbg;

    logic [EW-1:0] exp_q[$];
    int checks;
    int errors;

    rv32i_mem_stage #(.WAIT_MAX(WMAX)) dut (
        .clk(clk), .reset(reset),
        .ex_valid(ex_valid), .ex_ready(ex_ready),
        .ex_pc(ex_pc), .ex_iw(ex_iw), .ex_alu(ex_alu), .ex_rs2(ex_rs2),
        .ex_wb_en(ex_wb_en), .ex_wb_reg(ex_wb_reg),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .pc_out(pc_out), .iw_out(iw_out), .alu_out(alu_out),
        .wb_en_out(wb_en_out), .wb_reg_out(wb_reg_out), .bus_err(bus_err),
`ifdef MISALIGN_TRAP_EN
        .misalign_out(misalign_out),
`endif
        .state_dbg(state_dbg)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic int unsigned acc_size(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   return 1;
            2'b01:   return 2;
            default: return 4;
        endcase
    endfunction

    // First byte lane touched: address rounded down to the access size.
    function automatic int unsigned acc_base(input logic [2:0] f3, input logic [31:0] a);
        int unsigned sz;
        sz = acc_size(f3);
        return (int'(a[1:0]) / sz) * sz;
    endfunction

    function automatic logic [3:0] model_be(input logic [2:0] f3, input logic [31:0] a);
        logic [3:0] r;
        int unsigned b, sz;
        b  = acc_base(f3, a);
        sz = acc_size(f3);
        r  = 4'b0000;
        for (int k = 0; k < 4; k++) begin
            if (k >= b && k < b + sz) r[k] = 1'b1;
        end
        return r;
    endfunction

    function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] d);
        logic [31:0] r;
        int unsigned sz;
        sz = acc_size(f3);
        for (int k = 0; k < 4; k++) r[8*k +: 8] = d[8*(k % sz) +: 8];
        return r;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a,
                                               input logic [31:0] rd);
        logic [31:0] v;
        int unsigned b, sz;
        b  = acc_base(f3, a);
        sz = acc_size(f3);
        v  = 32'd0;
        for (int k = 0; k < 4; k++) begin
            if (k < sz) v[8*k +: 8] = rd[8*(b + k) +: 8];
        end
        if (sz < 4 && !f3[2] && v[8*sz - 1]) begin
            for (int k = 0; k < 4; k++) begin
                if (k >= sz) v[8*k +: 8] = 8'hFF;
            end
        end
        return v;
    endfunction

    function automatic logic [EW-1:0] pack_res(input logic [31:0] pc, input logic [31:0] iw,
                                               input logic [31:0] alu, input logic en,
                                               input logic [4:0] rg, input logic be);
        return {pc, iw, alu, en, rg, be};
    endfunction

    // ---------------- drivers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_ex(input logic [31:0] pc, input logic [31:0] iw, input logic [31:0] alu,
                            input logic [31:0] rs2, input logic en, input logic [4:0] rg);
        ex_valid  = 1'b1;
        ex_pc     = pc;
        ex_iw     = iw;
        ex_alu    = alu;
        ex_rs2    = rs2;
        ex_wb_en  = en;
        ex_wb_reg = rg;
    endtask

    task automatic drive_idle();
        ex_valid  = 1'b0;
        ex_pc     = $urandom;
        ex_iw     = $urandom;
        ex_alu    = $urandom;
        ex_rs2    = $urandom;
        ex_wb_en  = 1'b1;
        ex_wb_reg = 5'($urandom_range(0, 31));
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        logic [EW-1:0] exp_v, obs_v;
        reset = 1'b0;
        drive_ex(32'h10, {12'h103, 5'd0, 3'b010, 5'd6, 7'b0000011}, 32'h103, 32'h0, 1'b1, 5'd6);
        dmem_ack   = 1'b1;
        dmem_rdata = 32'hDEADBEEF;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
             pc_out, iw_out, alu_out, wb_en_out, wb_reg_out, bus_err} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: req=%b we=%b addr=%h be=%b wdata=%h pc=%h iw=%h alu=%h wb_en=%b reg=%0d err=%b, expected all zero",
                     dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata, pc_out, iw_out, alu_out,
                     wb_en_out, wb_reg_out, bus_err);
        end
        checks++;
        if (ex_ready !== 1'b1 || state_dbg !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: ready=%b state=%b, expected ready=1 state=0", ex_ready, state_dbg);
        end
        // ADDI x5 accepted on the very first edge with reset released.
        reset    = 1'b1;
        dmem_ack = 1'b0;
        drive_ex(32'h40, 32'h00500293, 32'd5, 32'h0, 1'b1, 5'd5);
        exp_q.push_back(pack_res(32'h40, 32'h00500293, 32'd5, 1'b1, 5'd5, 1'b0));
        tick();
        drive_idle();
        obs_v = pack_res(pc_out, iw_out, alu_out, wb_en_out, wb_reg_out, bus_err);
        exp_v = exp_q.pop_front();
        checks++;
        if (obs_v !== exp_v || dmem_req !== 1'b0) begin
            errors++;
            $display("FAIL addi_first: got %h req=%b, expected %h req=0", obs_v, dmem_req, exp_v);
        end
    endtask

    task automatic test_nonmem_stream();
        logic [EW-1:0] exp_v, obs_v;
        logic [31:0] r, pc, iw, alu;
        logic [4:0]  rg;
        logic        en;
        logic [6:0]  op;
        for (int i = 0; i < 10; i++) begin
            r  = $urandom;
            case ($urandom_range(0, 2))
                0:       op = 7'b0010011;
                1:       op = 7'b0110011;
                default: op = 7'b0110111;
            endcase
            iw  = {r[31:7], op};
            pc  = $urandom;
            alu = $urandom;
            en  = 1'($urandom_range(0, 1));
            rg  = (i == 3) ? 5'd0 : 5'($urandom_range(1, 31));
            if (i == 3) en = 1'b1;   // x0 writes pass through untouched
            drive_ex(pc, iw, alu, $urandom, en, rg);
            exp_q.push_back(pack_res(pc, iw, alu, en, rg, 1'b0));
            tick();
            obs_v = pack_res(pc_out, iw_out, alu_out, wb_en_out, wb_reg_out, bus_err);
            exp_v = exp_q.pop_front();
            checks++;
            if (obs_v !== exp_v || ex_ready !== 1'b1 || dmem_req !== 1'b0) begin
                errors++;
                $display("FAIL nonmem_%0d: got %h ready=%b req=%b, expected %h ready=1 req=0",
                         i, obs_v, ex_ready, dmem_req, exp_v);
            end
        end
        drive_idle();
        tick();
        checks++;
        if (wb_en_out !== 1'b0 || pc_out !== pc || alu_out !== alu) begin
            errors++;
            $display("FAIL bubble_hold: wb_en=%b pc=%h alu=%h, expected wb_en=0 pc=%h alu=%h",
                     wb_en_out, pc_out, alu_out, pc, alu);
        end
    endtask

    task automatic test_stray_ack();
        drive_idle();
        dmem_ack = 1'b1;
        tick();
        dmem_ack = 1'b0;
        checks++;
        if (wb_en_out !== 1'b0 || dmem_req !== 1'b0 || state_dbg !== 1'b0 || bus_err !== 1'b0) begin
            errors++;
            $display("FAIL stray_ack: wb_en=%b req=%b state=%b err=%b, expected all 0",
                     wb_en_out, dmem_req, state_dbg, bus_err);
        end
    endtask

    // Load acked in WAIT cycle n (n=1 means ack in the first WAIT cycle).
    task automatic test_load(input string name, input logic [2:0] f3, input logic [31:0] addr,
                             input logic [31:0] rdata, input int n);
        logic [EW-1:0] exp_v, obs_v;
        logic [31:0] pc, iw;
        logic [3:0]  exp_be;
        pc = $urandom;
        iw = {12'h000, 5'd1, f3, 5'd6, 7'b0000011};
        drive_ex(pc, iw, addr, $urandom, 1'b1, 5'd6);
        exp_q.push_back(pack_res(pc, iw, model_load(f3, addr, rdata), 1'b1, 5'd6, 1'b0));
        exp_be = model_be(f3, addr);
        tick();
        drive_idle();
        for (int k = 1; k <= n; k++) begin
            checks++;
            if (dmem_req !== 1'b1 || dmem_we !== 1'b0 || dmem_addr !== {addr[31:2], 2'b00} ||
                dmem_be !== exp_be || ex_ready !== 1'b0 || wb_en_out !== 1'b0 || state_dbg !== 1'b1) begin
                errors++;
                $display("FAIL %s_wait%0d: req=%b we=%b addr=%h be=%b ready=%b wb_en=%b state=%b, expected req=1 we=0 addr=%h be=%b ready=0 wb_en=0 state=1",
                         name, k, dmem_req, dmem_we, dmem_addr, dmem_be, ex_ready, wb_en_out, state_dbg,
                         {addr[31:2], 2'b00}, exp_be);
            end
            if (k == n) begin
                dmem_ack   = 1'b1;
                dmem_rdata = rdata;
            end
            tick();
        end
        dmem_ack   = 1'b0;
        dmem_rdata = $urandom;
        obs_v = pack_res(pc_out, iw_out, alu_out, wb_en_out, wb_reg_out, bus_err);
        exp_v = exp_q.pop_front();
        checks++;
        if (obs_v !== exp_v) begin
            errors++;
            $display("FAIL %s_result: got %h, expected %h", name, obs_v, exp_v);
        end
        checks++;
        if (dmem_req !== 1'b0 || ex_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s_done: req=%b ready=%b, expected req=0 ready=1", name, dmem_req, ex_ready);
        end
    endtask

    task automatic test_store(input string name, input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] rs2, input int n);
        logic [EW-1:0] exp_v, obs_v;
        logic [31:0] pc, iw, exp_wd;
        logic [3:0]  exp_be;
        pc = $urandom;
        iw = {7'h00, 5'd2, 5'd1, f3, 5'd0, 7'b0100011};
        drive_ex(pc, iw, addr, rs2, 1'b1, 5'd9);
        exp_q.push_back(pack_res(pc, iw, addr, 1'b0, 5'd9, 1'b0));
        exp_be = model_be(f3, addr);
        exp_wd = model_wdata(f3, rs2);
        tick();
        drive_idle();
        for (int k = 1; k <= n; k++) begin
            checks++;
            if (dmem_req !== 1'b1 || dmem_we !== 1'b1 || dmem_addr !== {addr[31:2], 2'b00} ||
                dmem_be !== exp_be || dmem_wdata !== exp_wd || ex_ready !== 1'b0) begin
                errors++;
                $display("FAIL %s_wait%0d: req=%b we=%b addr=%h be=%b wdata=%h ready=%b, expected req=1 we=1 addr=%h be=%b wdata=%h ready=0",
                         name, k, dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata, ex_ready,
                         {addr[31:2], 2'b00}, exp_be, exp_wd);
            end
            if (k == n) dmem_ack = 1'b1;
            tick();
        end
        dmem_ack = 1'b0;
        obs_v = pack_res(pc_out, iw_out, alu_out, wb_en_out, wb_reg_out, bus_err);
        exp_v = exp_q.pop_front();
        checks++;
        if (obs_v !== exp_v || dmem_req !== 1'b0) begin
            errors++;
            $display("FAIL %s_result: got %h req=%b, expected %h req=0", name, obs_v, dmem_req, exp_v);
        end
    endtask

    task automatic test_illegal(input string name, input logic [6:0] op, input logic [2:0] f3);
        logic [EW-1:0] exp_v, obs_v;
        logic [31:0] pc, iw, alu;
        pc  = $urandom;
        alu = 32'h0000_0200;
        iw  = {12'h000, 5'd1, f3, 5'd7, op};
        drive_ex(pc, iw, alu, $urandom, 1'b1, 5'd7);
        exp_q.push_back(pack_res(pc, iw, alu, 1'b0, 5'd7, 1'b0));
        tick();
        drive_idle();
        obs_v = pack_res(pc_out, iw_out, alu_out, wb_en_out, wb_reg_out, bus_err);
        exp_v = exp_q.pop_front();
        checks++;
        if (obs_v !== exp_v || dmem_req !== 1'b0 || ex_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s: got %h req=%b ready=%b, expected %h req=0 ready=1",
                     name, obs_v, dmem_req, ex_ready, exp_v);
        end
    endtask

    task automatic test_timeout();
        logic [EW-1:0] exp_v, obs_v;
        logic [31:0] pc, iw;
        pc = 32'h0000_0800;
        iw = {12'h000, 5'd1, 3'b010, 5'd8, 7'b0000011};
        drive_ex(pc, iw, 32'h0000_0300, 32'h0, 1'b1, 5'd8);
        exp_q.push_back(pack_res(pc, iw, 32'h0000_0300, 1'b0, 5'd8, 1'b1));
        tick();
        drive_idle();
        for (int k = 1; k <= WMAX; k++) begin
            checks++;
            if (dmem_req !== 1'b1 || bus_err !== 1'b0 || ex_ready !== 1'b0) begin
                errors++;
                $display("FAIL timeout_wait%0d: req=%b err=%b ready=%b, expected req=1 err=0 ready=0",
                         k, dmem_req, bus_err, ex_ready);
            end
            tick();
        end
        obs_v = pack_res(pc_out, iw_out, alu_out, wb_en_out, wb_reg_out, bus_err);
        exp_v = exp_q.pop_front();
        checks++;
        if (obs_v !== exp_v || dmem_req !== 1'b0 || ex_ready !== 1'b1) begin
            errors++;
            $display("FAIL timeout_abort: got %h req=%b ready=%b, expected %h req=0 ready=1",
                     obs_v, dmem_req, ex_ready, exp_v);
        end
        tick();
        checks++;
        if (bus_err !== 1'b0 || wb_en_out !== 1'b0) begin
            errors++;
            $display("FAIL timeout_pulse: err=%b wb_en=%b, expected err=0 wb_en=0", bus_err, wb_en_out);
        end
    endtask

    task automatic test_reset_wait();
        drive_ex(32'h0000_0900, {12'h000, 5'd1, 3'b010, 5'd10, 7'b0000011}, 32'h0000_0400,
                 32'h0, 1'b1, 5'd10);
        tick();
        drive_idle();
        tick();   // second WAIT cycle
        reset = 1'b0;
        #1;
        checks++;
        if ({dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
             pc_out, iw_out, alu_out, wb_en_out, wb_reg_out, bus_err, state_dbg} !== '0) begin
            errors++;
            $display("FAIL reset_in_wait: req=%b addr=%h be=%b pc=%h alu=%h wb_en=%b err=%b state=%b, expected all zero",
                     dmem_req, dmem_addr, dmem_be, pc_out, alu_out, wb_en_out, bus_err, state_dbg);
        end
        dmem_ack   = 1'b1;
        dmem_rdata = 32'h1234_5678;
        drive_ex(32'h44, 32'h00500293, 32'd5, 32'h0, 1'b1, 5'd5);
        @(posedge clk);
        #1;
        dmem_ack = 1'b0;
        drive_idle();
        reset = 1'b1;
        tick();
        checks++;
        if (wb_en_out !== 1'b0 || pc_out !== 32'd0 || alu_out !== 32'd0 || dmem_req !== 1'b0 ||
            bus_err !== 1'b0 || state_dbg !== 1'b0) begin
            errors++;
            $display("FAIL reset_no_result: wb_en=%b pc=%h alu=%h req=%b err=%b state=%b, expected all zero",
                     wb_en_out, pc_out, alu_out, dmem_req, bus_err, state_dbg);
        end
    endtask

    task automatic test_misalign();
`ifdef MISALIGN_TRAP_EN
        logic [EW-1:0] exp_v, obs_v;
        logic [31:0] pc, iw;
        pc = 32'h0000_0A00;
        iw = {12'h000, 5'd1, 3'b010, 5'd11, 7'b0000011};
        drive_ex(pc, iw, 32'h0000_0102, 32'h0, 1'b1, 5'd11);
        exp_q.push_back(pack_res(pc, iw, 32'h0000_0102, 1'b0, 5'd11, 1'b0));
        tick();
        drive_idle();
        obs_v = pack_res(pc_out, iw_out, alu_out, wb_en_out, wb_reg_out, bus_err);
        exp_v = exp_q.pop_front();
        checks++;
        if (obs_v !== exp_v || dmem_req !== 1'b0 || misalign_out !== 1'b1 || ex_ready !== 1'b1) begin
            errors++;
            $display("FAIL misalign_trap: got %h req=%b mis=%b ready=%b, expected %h req=0 mis=1 ready=1",
                     obs_v, dmem_req, misalign_out, ex_ready, exp_v);
        end
        tick();
        checks++;
        if (misalign_out !== 1'b0) begin
            errors++;
            $display("FAIL misalign_pulse: mis=%b, expected 0", misalign_out);
        end
`else
        test_load("lw_0x102", 3'b010, 32'h0000_0102, 32'hCAFE_F00D, 1);
        test_load("lh_0x101", 3'b001, 32'h0000_0101, 32'h1122_8344, 2);
        test_store("sw_0x103", 3'b010, 32'h0000_0103, 32'h0BAD_CAFE, 1);
`endif
    endtask

    task automatic test_random_loads();
        logic [2:0]  f3;
        logic [31:0] a;
        for (int i = 0; i < 8; i++) begin
            case ($urandom_range(0, 4))
                0:       f3 = 3'b000;
                1:       f3 = 3'b001;
                2:       f3 = 3'b100;
                3:       f3 = 3'b101;
                default: f3 = 3'b010;
            endcase
            a = $urandom;
`ifdef MISALIGN_TRAP_EN
            if (f3[1:0] == 2'b01) a[0] = 1'b0;
            if (f3[1:0] == 2'b10) a[1:0] = 2'b00;
`endif
            test_load("rand_load", f3, a, $urandom, $urandom_range(1, WMAX));
        end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        checks     = 0;
        errors     = 0;
        dmem_ack   = 1'b0;
        dmem_rdata = 32'h0;
        drive_idle();

        test_reset();
        test_nonmem_stream();
        test_stray_ack();
        test_load("lb_0x103", 3'b000, 32'h0000_0103, 32'h80AA_BBCC, 2);
        test_load("lbu_0x103", 3'b100, 32'h0000_0103, 32'h80AA_BBCC, 2);
        // Fixed spot checks of the reference model itself.
        checks++;
        if (model_load(3'b000, 32'h103, 32'h80AABBCC) !== 32'hFFFFFF80 ||
            model_load(3'b100, 32'h103, 32'h80AABBCC) !== 32'h00000080) begin
            errors++;
            $display("FAIL model_lb: got %h/%h, expected ffffff80/00000080",
                     model_load(3'b000, 32'h103, 32'h80AABBCC), model_load(3'b100, 32'h103, 32'h80AABBCC));
        end
        test_load("lh_0x102", 3'b001, 32'h0000_0102, 32'h9876_0011, 3);
        test_load("lhu_0x102", 3'b101, 32'h0000_0102, 32'h9876_0011, 1);
        test_load("lw_ack_first", 3'b010, 32'h0000_0200, 32'h0102_0304, 1);
        test_load("lw_ack_last", 3'b010, 32'h0000_0204, 32'hA5A5_5A5A, WMAX);
        test_store("sb_0x101", 3'b000, 32'h0000_0101, 32'h1234_ABCD, 1);
        test_store("sh_0x102", 3'b001, 32'h0000_0102, 32'h1234_ABCD, 2);
        test_store("sw_0x104", 3'b010, 32'h0000_0104, 32'h1234_ABCD, WMAX);
        test_illegal("load_f3_011", 7'b0000011, 3'b011);
        test_illegal("load_f3_110", 7'b0000011, 3'b110);
        test_illegal("store_f3_100", 7'b0100011, 3'b100);
        test_timeout();
        test_random_loads();
        test_reset_wait();
        test_misalign();

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rv32i_mem_stage.md
RV32I_MEM_STAGE -- requirements
Module: rv32i_mem_stage

Interface
REQ-001 SHALL have parameter WAIT_MAX, default 16, the maximum number of WAIT cycles before an access is aborted (range 1-255).
REQ-002 SHALL have port clk  input  1  single system clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have ports ex_valid in 1; ex_ready out 1; ex_pc, ex_iw, ex_alu, ex_rs2 in 32; ex_wb_en in 1; ex_wb_reg in 5 (execute-stage instruction, address/result, store data, writeback control).
REQ-005 SHALL have ports dmem_req out 1; dmem_we out 1; dmem_addr out 32 (word-aligned, [1:0]=0); dmem_be out 4; dmem_wdata out 32; dmem_ack in 1; dmem_rdata in 32.
REQ-006 SHALL have ports pc_out, iw_out, alu_out out 32; wb_en_out out 1; wb_reg_out out 5; bus_err out 1 (writeback-stage feed, registered).

Function
REQ-007 SHALL accept an instruction on a rising edge where ex_valid=1 and ex_ready=1; ex_ready SHALL be 1 exactly when state is IDLE.
REQ-008 SHALL classify by ex_iw[6:0]: 0000011 LOAD, 0100011 STORE, otherwise non-memory; funct3=ex_iw[14:12].
REQ-009 Non-memory: SHALL register pc/iw/alu/wb_en/wb_reg to outputs with 1-cycle latency, state stays IDLE, throughput 1/cycle.
REQ-010 LOAD/STORE: SHALL capture instruction, go IDLE->WAIT; in WAIT SHALL hold dmem_req=1 and dmem_we/addr/be/wdata stable until ack or abort.
REQ-011 Store: dmem_we=1; SB be=0001<<addr[1:0], wdata={4{rs2[7:0]}}; SH be=0011<<addr[1:0], wdata={2{rs2[15:0]}}; SW be=1111, wdata=rs2.
REQ-012 Load: dmem_we=0, be as for same-size store; result byte/halfword selected by addr[1:0]; LB/LH sign-extend, LBU/LHU zero-extend, LW unmodified.
REQ-013 Load with funct3 011/110/111 or store with funct3 >010: SHALL make no access and complete as non-memory with wb_en_out=0.
REQ-014 On dmem_ack=1 in WAIT: SHALL return to IDLE and present next cycle pc_out/iw_out, alu_out=extended load data (load) or ex_alu (store), wb_en_out=captured wb_en (load) or 0 (store).
REQ-015 dmem_ack outside WAIT SHALL be ignored; ack on first WAIT cycle SHALL be legal.
REQ-016 Each cycle a valid result is not produced (IDLE without accept, or WAIT without ack/abort), wb_en_out SHALL be 0 (bubble); pc/iw/alu outputs hold.
REQ-017 SHALL count WAIT cycles; if WAIT_MAX cycles pass without ack, SHALL drop dmem_req, return to IDLE, output the instruction with wb_en_out=0 and bus_err=1 for one cycle.
REQ-018 Ack arriving in the same cycle as the count reaching WAIT_MAX SHALL be treated as success (no bus_err).
REQ-019 Writes to register x0 SHALL be forwarded unchanged (writeback handles x0).

Reset
REQ-020 reset=0 SHALL immediately force state IDLE, wait counter 0, dmem_req=0, dmem_we=0, dmem_be=0, dmem_addr=0, dmem_wdata=0, all *_out=0, bus_err=0.
REQ-021 Reset during WAIT SHALL abort the access with no result; ex_valid SHALL be ignored while reset=0.
REQ-022 First accept SHALL occur on the first rising edge with reset=1.

Configuration
REQ-023 Macro MISALIGN_TRAP_EN defined: SHALL add port misalign_out out 1; halfword with addr[0]=1 or word with addr[1:0]!=00 SHALL make no access, complete in 1 cycle with wb_en_out=0, misalign_out=1 for one cycle.
REQ-024 MISALIGN_TRAP_EN undefined: no misalign_out port; halfword accesses SHALL treat addr[0] as 0, word accesses addr[1:0] as 00.

Verification
REQ-025 ADDI x5 (iw=0x00500293, alu=5, wb_en=1) -> next cycle alu_out=5, wb_reg_out=5, wb_en_out=1, dmem_req=0.
REQ-026 LB x6, addr 0x103, ack after 2 WAIT cycles, rdata=0x80AABBCC -> alu_out=0xFFFFFF80, wb_en_out=1; LBU same -> 0x00000080; ex_ready=0 throughout WAIT.
REQ-027 SH addr 0x102, rs2=0x1234ABCD -> dmem_addr=0x100, be=1100, wdata=0xABCDABCD, we=1; after ack wb_en_out=0.
REQ-028 LW, WAIT_MAX=4, no ack -> dmem_req drops after 4 WAIT cycles, bus_err=1 one cycle, wb_en_out=0, ex_ready=1 next cycle.
REQ-029 reset=0 asserted in 2nd WAIT cycle, ack next cycle -> all outputs 0 immediately, ack ignored, no result.
REQ-030 LW addr 0x102: with MISALIGN_TRAP_EN -> no dmem_req, misalign_out=1, wb_en_out=0; without -> dmem_addr=0x100, be=1111.
